// File: rtl/encode_packet_serializer_if.sv
// encode_packet_serializer_if: packet request and flit link between controller, serializer and router lane
interface encode_packet_serializer_if #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int FLIT_WIDTH = 256
);
    logic                             start_encode_pkt;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] data_dfx_send;
    logic                             ready_encode_pkt;
    logic                             encode_done;
    logic                             flit_valid;
    logic                             flit_ready;
    logic [1:0]                       flit_type;
    logic [FLIT_WIDTH-1:0]            flit_data;
    modport master (
        output start_encode_pkt, data_dfx_send, flit_ready,
        input  ready_encode_pkt, encode_done, flit_valid, flit_type, flit_data
    );
    modport slave (
        input  start_encode_pkt, data_dfx_send, flit_ready,
        output ready_encode_pkt, encode_done, flit_valid, flit_type, flit_data
    );
endinterface

// File: rtl/encode_packet_serializer.sv
// encode_packet_serializer: turns one {payload, dst_addr} word into a head flit plus NUM_BODY payload flits
module encode_packet_serializer #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int FLIT_WIDTH = 256
) (
    input logic clk,
    input logic rst,
    encode_packet_serializer_if.slave bus
);
    localparam int NUM_BODY = DATA_WIDTH / FLIT_WIDTH;
    localparam int CW = $clog2(NUM_BODY + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_BODY - 1);
    typedef enum logic [1:0] {IDLE, HEAD, BODY, DONE} state_t;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_seq;
    logic [DATA_WIDTH-1:0] r_payload;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic                  r_done;
    logic                  r_valid;
    logic [1:0]            r_type;
    logic [FLIT_WIDTH-1:0] r_data;
    logic [CW-1:0]         w_nxt;
    assign w_nxt = r_cnt + 1'b1;
    assign bus.ready_encode_pkt = r_state == IDLE;
    assign bus.encode_done = r_done;
    assign bus.flit_valid = r_valid;
    assign bus.flit_type = r_type;
    assign bus.flit_data = r_data;
    // Flit outputs are loaded one state ahead so they stay registered and stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_seq     <= '0;
            r_payload <= '0;
            r_dst     <= '0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_type    <= 2'b00;
            r_data    <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start_encode_pkt) begin
                    r_payload <= bus.data_dfx_send[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
                    r_dst     <= bus.data_dfx_send[ADDR_WIDTH-1:0];
                    r_valid   <= 1'b1;
                    r_type    <= 2'b01;
                    r_data    <= FLIT_WIDTH'({8'(NUM_BODY), r_seq, bus.data_dfx_send[ADDR_WIDTH-1:0]});
                    r_state   <= HEAD;
                end
                HEAD: if (bus.flit_ready) begin
                    r_cnt   <= '0;
                    r_data  <= r_payload[0 +: FLIT_WIDTH];
                    r_type  <= (NUM_BODY == 1) ? 2'b10 : 2'b00;
                    r_state <= BODY;
                end
                BODY: if (bus.flit_ready) begin
                    if (r_cnt == LAST) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_type  <= 2'b00;
                        r_data  <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt  <= w_nxt;
                        r_data <= r_payload[w_nxt*FLIT_WIDTH +: FLIT_WIDTH];
                        r_type <= (w_nxt == LAST) ? 2'b10 : 2'b00;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_seq   <= r_seq + 8'd1;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encode_packet_serializer.sv
// tb_encode_packet_serializer: directed and randomized packets checked against a flit-list reference model
module tb_encode_packet_serializer;
    localparam int DW = 1024;
    localparam int AW = 10;
    localparam int FW = 256;
    localparam int NB = DW / FW;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_seq = 8'd0;
    encode_packet_serializer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIT_WIDTH(FW)) bus ();
    encode_packet_serializer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIT_WIDTH(FW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [DW-1:0] rnd_payload();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    // mode 0: ready held high, 1: ready pattern 1,0,0, 2: start pulse while busy, 3: reset after 2nd body
    task automatic send(input logic [DW-1:0] pl, input logic [AW-1:0] dst, input int mode);
        logic [FW-1:0] ef [NB+1];
        logic [1:0] et [NB+1];
        int idx, cyc, w;
        ef[0] = FW'(dst) | (FW'(exp_seq) << AW) | (FW'(NB) << (AW + 8));
        et[0] = 2'b01;
        for (int i = 1; i <= NB; i++) begin
            ef[i] = FW'(pl >> ((i - 1) * FW));
            et[i] = (i == NB) ? 2'b10 : 2'b00;
        end
        w = 0;
        while (bus.ready_encode_pkt !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_start", FW'(bus.ready_encode_pkt), FW'(1));
        bus.start_encode_pkt = 1'b1;
        bus.data_dfx_send = {pl, dst};
        @(negedge clk);
        bus.start_encode_pkt = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx <= NB && cyc < 100) begin
            if (mode == 3 && idx == 3) begin
                rst = 1'b1;
                #1;
                chk("abort_valid", FW'(bus.flit_valid), FW'(0));
                chk("abort_done", FW'(bus.encode_done), FW'(0));
                chk("abort_ready", FW'(bus.ready_encode_pkt), FW'(1));
                chk("abort_type", FW'(bus.flit_type), FW'(0));
                chk("abort_data", bus.flit_data, FW'(0));
                bus.flit_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                exp_seq = 8'd0;
                return;
            end
            chk("flit_valid", FW'(bus.flit_valid), FW'(1));
            chk("flit_type", FW'(bus.flit_type), FW'(et[idx]));
            chk("flit_data", bus.flit_data, ef[idx]);
            chk("busy_ready", FW'(bus.ready_encode_pkt), FW'(0));
            chk("early_done", FW'(bus.encode_done), FW'(0));
            bus.flit_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            bus.start_encode_pkt = (mode == 2 && cyc == 2);
            if (mode == 2 && cyc == 2) bus.data_dfx_send = ~bus.data_dfx_send;
            if (bus.flit_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.start_encode_pkt = 1'b0;
        chk("all_flits_sent", FW'(idx), FW'(NB + 1));
        if (mode == 0) chk("tail_latency", FW'(cyc), FW'(NB + 1));
        chk("done_pulse", FW'(bus.encode_done), FW'(1));
        chk("done_valid", FW'(bus.flit_valid), FW'(0));
        chk("done_ready", FW'(bus.ready_encode_pkt), FW'(0));
        @(negedge clk);
        chk("done_cleared", FW'(bus.encode_done), FW'(0));
        chk("idle_ready", FW'(bus.ready_encode_pkt), FW'(1));
        exp_seq++;
    endtask
    initial begin
        logic [DW-1:0] pl;
        rst = 1'b1;
        bus.start_encode_pkt = 1'b0;
        bus.flit_ready = 1'b0;
        bus.data_dfx_send = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", FW'(bus.ready_encode_pkt), FW'(1));
        chk("rst_valid", FW'(bus.flit_valid), FW'(0));
        chk("rst_done", FW'(bus.encode_done), FW'(0));
        chk("rst_type", FW'(bus.flit_type), FW'(0));
        chk("rst_data", bus.flit_data, FW'(0));
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_flit", FW'(bus.flit_valid), FW'(0));
        end
        pl = {{64{4'hD}}, {64{4'hC}}, {64{4'hB}}, {64{4'hA}}};
        send(pl, 10'h2A5, 0);
        send(rnd_payload(), AW'($urandom), 1);
        send(rnd_payload(), AW'($urandom), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 8'd0;
        for (int p = 0; p < 257; p++) send(rnd_payload(), AW'($urandom), 0);
        send(rnd_payload(), AW'($urandom), 3);
        send(rnd_payload(), AW'($urandom), 0);
        send(rnd_payload(), AW'($urandom), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
